// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types for the APB requester
package apb_pkg;

  // Width of the response data field carried in the response register
  localparam int RSP_DATA_W = 64;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2
  } apb_mst_state_e;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Response loaded when the completer never raised PREADY in time
  function automatic apb_rsp_t rsp_abort();
    apb_rsp_t r;
    r.rdata   = '0;
    r.err     = 1'b1;
    r.timeout = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/apb_master_fsm_if.sv
// rtl/apb_master_fsm_if.sv - command/response streams and APB bus of the requester
interface apb_master_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB bus toward one completer
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // requester view
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // environment / completer view
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - ACCESS wait-cycle counter that flags the abort cycle
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      // timeout disabled: the requester waits on PREADY forever
      logic unused_inputs;
      assign unused_inputs = clk ^ rst ^ clear ^ enable;
      assign expire        = 1'b0;
    end else begin : g_on
      localparam int            CW   = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // expire marks the last PREADY-low cycle allowed; it stops the count, so it never wraps
      assign expire = enable && (cnt_q == LAST);

      // next count: clear on a new transfer, step on each PREADY-low ACCESS cycle
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable && !expire) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // count register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB requester turning command stream into SETUP/ACCESS transfers
module apb_master_fsm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_master_fsm_if.master bus
);

  import apb_pkg::*;

  apb_mst_state_e    state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  apb_rsp_t          rsp_q, rsp_d;

  logic cmd_ready;
  logic cmd_fire;
  logic rsp_fire;
  logic ctr_enable;
  logic ctr_expire;

  // A command is taken only in IDLE and only if the response slot is free or being emptied now.
  // Held low while reset is asserted so every output reads 0 during reset.
  assign cmd_ready  = !PRESET && (state_q == M_IDLE) && (!rsp_valid_q || bus.rsp_ready);
  assign cmd_fire   = cmd_ready && bus.cmd_valid;
  assign rsp_fire   = rsp_valid_q && bus.rsp_ready;
  assign ctr_enable = (state_q == M_ACCESS) && !bus.PREADY;

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (cmd_fire),
    .enable (ctr_enable),
    .expire (ctr_expire)
  );

  // next-state, bus latch and response register updates
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q && !rsp_fire;
    rsp_d       = rsp_q;

    case (state_q)
      M_IDLE: begin
        if (cmd_fire) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          state_d  = M_SETUP;
        end
      end

      M_SETUP: begin
        state_d = M_ACCESS;
      end

      M_ACCESS: begin
        if (bus.PREADY) begin
          // PREADY wins over an expiring counter in the same cycle
          rsp_d.rdata   = pwrite_q ? '0 : RSP_DATA_W'(bus.PRDATA);
          rsp_d.err     = bus.PSLVERR;
          rsp_d.timeout = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = M_IDLE;
        end else if (ctr_expire) begin
          rsp_d       = rsp_abort();
          rsp_valid_d = 1'b1;
          state_d     = M_IDLE;
        end
      end

      default: begin
        state_d = M_IDLE;
      end
    endcase
  end

  // state, bus and response registers; reset discards any in-flight transfer and response
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= M_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.PSELx       = (state_q != M_IDLE);
  assign bus.PENABLE     = (state_q == M_ACCESS);
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - bench for the APB requester with a behavioural completer
module tb_apb_master_fsm;

  logic PCLK;
  logic PRESET;

  apb_master_fsm_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  apb_master_fsm #(
    .ADDR_W  (32),
    .DATA_W  (64),
    .TIMEOUT (4)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural completer: PREADY after wait_cfg low ACCESS cycles, or never when hang
  int unsigned wait_cfg = 0;
  bit          hang     = 1'b0;
  bit          err_mode = 1'b0;
  int unsigned acc_cnt  = 0;
  logic [63:0] mem [0:15];

  always_comb begin
    bus.PREADY  = bus.PSELx && bus.PENABLE && !hang && (acc_cnt == wait_cfg);
    bus.PSLVERR = bus.PREADY && err_mode;
    bus.PRDATA  = mem[bus.PADDR[6:3]];
  end

  always @(posedge PCLK) begin
    if (bus.PSELx && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (bus.PSELx && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR[6:3]] <= bus.PWDATA;
  end

  // scoreboard of expected responses, popped on each response handshake
  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push_exp(input logic [63:0] rdata, input logic err, input logic to);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.to    = to;
    sb.push_back(e);
  endtask

  always @(negedge PCLK) begin
    if (!PRESET && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        check_eq("rsp_err", bus.rsp_err, mon_e.err);
        check_eq("rsp_timeout", bus.rsp_timeout, mon_e.to);
      end
    end
  end

  // drives a command from just after an edge; returns just after the handshake edge N
  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [63:0] wd);
    bit ok;
    ok            = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    if (!ok) check_eq("cmd_accept_bound", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge PCLK);
    #1;
    if (!seen) check_eq(tag, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    PRESET        = 1'b1;

    // reset state
    @(negedge PCLK);
    check_eq("rst_psel", bus.PSELx, 0);
    check_eq("rst_penable", bus.PENABLE, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 0);
    check_eq("rst_paddr", bus.PADDR, 0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("idle_cmd_ready", bus.cmd_ready, 1);
    @(posedge PCLK);
    #1;

    // single write, zero wait states
    wait_cfg = 0;
    push_exp(64'd0, 1'b0, 1'b0);
    send_cmd(1'b1, 32'h10, 64'hDEAD_BEEF);
    @(negedge PCLK);
    check_eq("w_setup_psel", bus.PSELx, 1);
    check_eq("w_setup_penable", bus.PENABLE, 0);
    check_eq("w_setup_paddr", bus.PADDR, 64'h10);
    check_eq("w_setup_pwrite", bus.PWRITE, 1);
    check_eq("w_setup_pwdata", bus.PWDATA, 64'hDEAD_BEEF);
    check_eq("w_setup_cmd_ready", bus.cmd_ready, 0);
    @(negedge PCLK);
    check_eq("w_access_penable", bus.PENABLE, 1);
    check_eq("w_access_rsp_valid", bus.rsp_valid, 0);
    @(negedge PCLK);
    check_eq("w_n3_rsp_valid", bus.rsp_valid, 1);
    check_eq("w_n3_psel", bus.PSELx, 0);
    @(posedge PCLK);
    #1;

    // read with one wait state, like the slave FSM
    push_exp(64'd0, 1'b0, 1'b0);
    send_cmd(1'b1, 32'h20, 64'h1234);
    wait_rsp("w20_rsp_bound");
    wait_cfg = 1;
    push_exp(64'h1234, 1'b0, 1'b0);
    send_cmd(1'b0, 32'h20, 64'h0);
    @(negedge PCLK);
    check_eq("r_setup_paddr", bus.PADDR, 64'h20);
    @(negedge PCLK);
    check_eq("r_acc1_penable", bus.PENABLE, 1);
    check_eq("r_acc1_rsp_valid", bus.rsp_valid, 0);
    @(negedge PCLK);
    check_eq("r_acc2_penable", bus.PENABLE, 1);
    check_eq("r_acc2_paddr", bus.PADDR, 64'h20);
    check_eq("r_acc2_rsp_valid", bus.rsp_valid, 0);
    @(negedge PCLK);
    check_eq("r_n4_rsp_valid", bus.rsp_valid, 1);
    @(posedge PCLK);
    #1;
    push_exp(64'hDEAD_BEEF, 1'b0, 1'b0);
    send_cmd(1'b0, 32'h10, 64'h0);
    wait_rsp("r10_rsp_bound");

    // slave error on a read, then a normal write
    wait_cfg = 0;
    err_mode = 1'b1;
    push_exp(64'h1234, 1'b1, 1'b0);
    send_cmd(1'b0, 32'h20, 64'h0);
    wait_rsp("err_rsp_bound");
    err_mode = 1'b0;
    push_exp(64'd0, 1'b0, 1'b0);
    send_cmd(1'b1, 32'h28, 64'h55);
    wait_rsp("after_err_rsp_bound");

    // timeout: PREADY never rises, abort after 4 ACCESS cycles
    hang = 1'b1;
    push_exp(64'd0, 1'b1, 1'b1);
    send_cmd(1'b0, 32'h20, 64'h0);
    @(negedge PCLK);
    check_eq("to_setup_penable", bus.PENABLE, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      check_eq("to_access_penable", bus.PENABLE, 1);
      check_eq("to_access_rsp_valid", bus.rsp_valid, 0);
    end
    @(negedge PCLK);
    check_eq("to_end_psel", bus.PSELx, 0);
    check_eq("to_end_penable", bus.PENABLE, 0);
    check_eq("to_end_rsp_valid", bus.rsp_valid, 1);
    @(posedge PCLK);
    #1;
    hang = 1'b0;

    // PREADY arrives in the cycle that would otherwise abort
    wait_cfg = 3;
    push_exp(64'hDEAD_BEEF, 1'b0, 1'b0);
    send_cmd(1'b0, 32'h10, 64'h0);
    repeat (5) @(negedge PCLK);
    check_eq("late_n5_penable", bus.PENABLE, 1);
    @(negedge PCLK);
    check_eq("late_n6_rsp_valid", bus.rsp_valid, 1);
    check_eq("late_n6_psel", bus.PSELx, 0);
    @(posedge PCLK);
    #1;

    // response backpressure blocks the next command until consumed
    wait_cfg      = 0;
    bus.rsp_ready = 1'b0;
    push_exp(64'd0, 1'b0, 1'b0);
    send_cmd(1'b1, 32'h38, 64'hA5A5);
    wait_rsp("bp_first_rsp_bound");
    push_exp(64'hA5A5, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h38;
    bus.cmd_wdata = 64'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check_eq("bp_cmd_ready", bus.cmd_ready, 0);
      check_eq("bp_psel", bus.PSELx, 0);
      check_eq("bp_rsp_valid", bus.rsp_valid, 1);
      @(posedge PCLK);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    check_eq("bp_release_cmd_ready", bus.cmd_ready, 1);
    @(posedge PCLK);
    #1;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    check_eq("bp_setup_psel", bus.PSELx, 1);
    check_eq("bp_setup_penable", bus.PENABLE, 0);
    check_eq("bp_setup_paddr", bus.PADDR, 64'h38);
    check_eq("bp_setup_pwrite", bus.PWRITE, 0);
    check_eq("bp_setup_rsp_valid", bus.rsp_valid, 0);
    @(posedge PCLK);
    #1;
    bus.rsp_ready = 1'b1;
    wait_rsp("bp_second_rsp_bound");

    // asynchronous reset during ACCESS discards the transfer
    hang = 1'b1;
    send_cmd(1'b0, 32'h10, 64'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    check_eq("ar_access_penable", bus.PENABLE, 1);
    #2;
    PRESET = 1'b1;
    #1;
    check_eq("ar_psel", bus.PSELx, 0);
    check_eq("ar_penable", bus.PENABLE, 0);
    check_eq("ar_rsp_valid", bus.rsp_valid, 0);
    hang = 1'b0;
    @(posedge PCLK);
    #1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("ar_post_cmd_ready", bus.cmd_ready, 1);
    check_eq("ar_post_psel", bus.PSELx, 0);
    check_eq("ar_post_rsp_valid", bus.rsp_valid, 0);
    @(posedge PCLK);
    #1;

    // normal transfer after the reset
    push_exp(64'hA5A5, 1'b0, 1'b0);
    send_cmd(1'b0, 32'h38, 64'h0);
    wait_rsp("final_rsp_bound");

    repeat (3) @(negedge PCLK);
    check_eq("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_fsm.md
# apb_master_fsm

APB requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns each completion on a valid/ready response stream. It drives PSELx, PENABLE, PADDR, PWRITE and PWDATA toward one APB completer, such as the existing APB slave FSM plus memory. It waits on PREADY, captures PRDATA and PSLVERR, and aborts transfers that exceed a programmable wait limit.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 64, APB data width (matches the completer)
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout
- PCLK  in  1  clock, rising edge
- PRESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data, ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR was sampled high at completion, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB completer ready
- PSLVERR  in  1  APB error, valid only with PREADY

## Operation
- States: M_IDLE, M_SETUP, M_ACCESS. All outputs are registered or decoded from the state register.
- Reset value of every output is 0, and the state resets to M_IDLE.
- M_IDLE: PSELx=0, PENABLE=0.
  - cmd_ready = !rsp_valid | rsp_ready.
  - On a command handshake, latch cmd_addr, cmd_write and cmd_wdata into PADDR, PWRITE and PWDATA, then go to M_SETUP.
- M_SETUP: PSELx=1, PENABLE=0, cmd_ready=0. Lasts exactly one cycle, then goes to M_ACCESS.
- M_ACCESS: PSELx=1, PENABLE=1, cmd_ready=0.
  - PREADY=1: load the response register and go to M_IDLE.
    - rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_err = PSLVERR.
    - rsp_timeout = 0.
  - PREADY=0: increment the wait counter.
    - When the counter equals TIMEOUT-1 and PREADY is still 0, load the response with rdata=0, err=1, timeout=1, then go to M_IDLE.
- Wait counter: width $clog2(TIMEOUT+1). Cleared on entry to M_SETUP. Never wraps, because the abort happens first.
- PADDR, PWRITE and PWDATA hold from SETUP through the last ACCESS cycle, and keep their last value in M_IDLE.
- Response register:
  - rsp_valid sets on completion and clears on rsp_valid & rsp_ready.
  - Data fields hold while rsp_valid is high.
  - A completion cannot occur while a response is pending, because cmd_ready gating guarantees this.
- Simultaneous events:
  - A rsp_ready consumption and a new command acceptance in the same M_IDLE cycle are both honoured.
  - PREADY=1 in the timeout cycle counts as a normal completion, not a timeout.
- Reset mid-transfer:
  - PSELx and PENABLE drop immediately (asynchronously).
  - The in-flight transfer and any pending response are discarded.

## Timing
- Command handshake at edge N: SETUP is visible in cycle N+1 and ACCESS from cycle N+2.
- If PREADY is high in cycle N+2, rsp_valid is high from N+3. The minimum latency from command to response is 3 cycles.
- Each PREADY-low ACCESS cycle adds 1 cycle.
  - The existing slave FSM raises PREADY in the second ACCESS cycle, so its latency is 4 cycles.
- Maximum throughput is one transfer per 3 cycles. At least one M_IDLE cycle with PSELx=0 separates transfers; there is no back-to-back SETUP.
- TIMEOUT=T with PREADY held low: the abort response is visible at N+2+T.
- PSLVERR and PRDATA are sampled only on the edge where PREADY=1 in M_ACCESS.

## Structure
- Shared package apb_pkg:
  - apb_mst_state_e, a 2-bit enum {M_IDLE, M_SETUP, M_ACCESS}.
  - Response struct {rdata, err, timeout}.
- Sub-module apb_timeout_ctr:
  - Parameter TIMEOUT; inputs clear and enable; output expire.
  - Ties expire to 0 when TIMEOUT=0.
- Everything else lives in the top module.

## Test plan
- Single write, addr 0x10, wdata 0xDEAD_BEEF, PREADY tied 1 -> SETUP at N+1, ACCESS at N+2; rsp_valid at N+3 with rdata=0, err=0, timeout=0.
- Read paired with the existing slave FSM returning 0x1234 -> PREADY in the second ACCESS cycle; rsp_rdata=0x1234 at N+4; PADDR stable throughout.
- Read with PSLVERR=1 and PREADY=1 -> rsp_err=1, rsp_timeout=0; the next command is accepted normally.
- TIMEOUT=4, PREADY held 0 -> PSELx and PENABLE drop after 4 ACCESS cycles; response has err=1, timeout=1, rdata=0.
- Backpressure: rsp_ready held 0 after a completion -> cmd_ready stays 0 and a second command waits. Raising rsp_ready for 1 cycle consumes the response and accepts the second command in the same cycle.
- PRESET asserted during M_ACCESS -> PSELx, PENABLE and rsp_valid go to 0 without a clock edge; after release the FSM is in M_IDLE with cmd_ready=1.
